// File: rtl/sliding_extremum_if.sv
// Sample/result bundle for the sliding extremum tracker.
// The master drives the samples and control; the slave returns the results.
interface sliding_extremum_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_WIN    = 10
);
  localparam int unsigned WLW = $clog2(MAX_WIN + 1);
  localparam int unsigned AW  = $clog2(MAX_WIN);

  logic                  clr;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] xin;
  logic                  mode;
  logic [WLW-1:0]        win_len;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] yout;
  logic [AW-1:0]         yage;
  logic                  filled;
  logic [DATA_WIDTH-1:0] last_slope;

  modport master (
    output clr, in_valid, xin, mode, win_len,
    input  out_valid, yout, yage, filled, last_slope
  );

  modport slave (
    input  clr, in_valid, xin, mode, win_len,
    output out_valid, yout, yage, filled, last_slope
  );
endinterface

// File: rtl/sliding_extremum.sv
// Running max/min over the newest win_len accepted samples, with the age of the winner.
// Window length and mode are latched on clr; results appear one cycle after each accept.
module sliding_extremum #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_WIN    = 10,
  parameter bit          SIGNED     = 1'b1,
  localparam int unsigned WLW       = $clog2(MAX_WIN + 1),
  localparam int unsigned AW        = $clog2(MAX_WIN)
) (
  input logic               clk,
  input logic               rstn,
  sliding_extremum_if.slave bus
);

  typedef enum logic [0:0] {StFilling, StFull} state_e;

  logic [DATA_WIDTH-1:0] r_hist [MAX_WIN];
  logic [WLW-1:0]        r_cnt;
  logic [WLW-1:0]        r_win;
  logic                  r_mode;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_yout;
  logic [AW-1:0]         r_yage;
  logic [DATA_WIDTH-1:0] r_last_slope;
  state_e                r_state;

  logic [DATA_WIDTH-1:0] w_hist_nxt [MAX_WIN];
  logic [WLW-1:0]        w_cnt_nxt;
  logic [WLW-1:0]        w_win_clamped;
  logic [DATA_WIDTH-1:0] w_best;
  logic [AW-1:0]         w_age;
  state_e                w_state_nxt;

  // Strictly-better test; equal values never displace the newer candidate.
  function automatic logic beats(input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] b,
                                 input logic                  is_min);
    logic gt, lt;
    if (SIGNED) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return is_min ? lt : gt;
  endfunction

  always_comb begin
    w_hist_nxt[0] = bus.xin;
    for (int unsigned i = 1; i < MAX_WIN; i++) begin
      w_hist_nxt[i] = r_hist[i-1];
    end

    w_cnt_nxt = (r_cnt < r_win) ? r_cnt + WLW'(1) : r_win;

    w_best = w_hist_nxt[0];
    w_age  = '0;
    for (int unsigned i = 1; i < MAX_WIN; i++) begin
      if ((WLW'(i) < w_cnt_nxt) && beats(w_hist_nxt[i], w_best, r_mode)) begin
        w_best = w_hist_nxt[i];
        w_age  = AW'(i);
      end
    end

    if (bus.win_len == '0) begin
      w_win_clamped = WLW'(1);
    end else if (bus.win_len > WLW'(MAX_WIN)) begin
      w_win_clamped = WLW'(MAX_WIN);
    end else begin
      w_win_clamped = bus.win_len;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr) begin
      w_state_nxt = StFilling;
    end else if (bus.in_valid && (w_cnt_nxt == r_win)) begin
      w_state_nxt = StFull;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StFilling;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < MAX_WIN; i++) r_hist[i] <= '0;
      r_cnt        <= '0;
      r_win        <= WLW'(MAX_WIN);
      r_mode       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_yout       <= '0;
      r_yage       <= '0;
      r_last_slope <= '0;
    end else if (bus.clr) begin
      // clr wins over a coincident accept: the sample is dropped.
      for (int unsigned i = 0; i < MAX_WIN; i++) r_hist[i] <= '0;
      r_cnt        <= '0;
      r_win        <= w_win_clamped;
      r_mode       <= bus.mode;
      r_out_valid  <= 1'b0;
      r_yout       <= '0;
      r_yage       <= '0;
      r_last_slope <= '0;
    end else if (bus.in_valid) begin
      for (int unsigned i = 0; i < MAX_WIN; i++) r_hist[i] <= w_hist_nxt[i];
      r_cnt        <= w_cnt_nxt;
      r_out_valid  <= 1'b1;
      r_yout       <= w_best;
      r_yage       <= w_age;
      r_last_slope <= r_yout;
    end else begin
      r_out_valid  <= 1'b0;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.yout       = r_yout;
  assign bus.yage       = r_yage;
  assign bus.filled     = (r_state == StFull);
  assign bus.last_slope = r_last_slope;

endmodule
